mult_div_unit: RTL and testbench

Multi-cycle multiply/divide unit (MDU) that sits beside the combinational ALU in the execute stage of the pipelined MIPS core. It accepts one operation per start pulse, holds busy for a fixed latency, and commits results to the architectural HI/LO registers. The pipeline reads HI/LO through `hi`/`lo` (mfhi/mflo) and stalls on `busy`. Operands and opcode are presented the way the ALU receives them: `A`, `B`, and a 3-bit op code.

---
 rtl/mult_div_unit_pkg.sv | 30 +++
 rtl/mult_div_unit_md_compute.sv | 55 +++++
 rtl/mult_div_unit.sv | 93 +++++++++
 tb/tb_mult_div_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared MIPS execute-stage definitions: ALU and multiply/divide opcodes
// plus the default multiply/divide latencies.
package mips_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_op_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOR = 3'b101,
    ALU_SLT = 3'b110,
    ALU_LUI = 3'b111
  } alu_op_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mult_div_unit_md_compute.sv
// Combinational HI/LO result generation for mult/multu/div/divu,
// plus a flag for division by zero.
module md_compute
  import mips_defs::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic        [31:0] a_mag, b_mag, b_safe, bu_safe;
  logic        [31:0] mag_q, mag_r;
  logic        [31:0] squot, srem;

  assign sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign uprod = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out naturally
  // as quotient 0x80000000, remainder 0.
  assign a_mag   = A[31] ? (32'd0 - A) : A;
  assign b_mag   = B[31] ? (32'd0 - B) : B;
  assign b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign bu_safe = (B == 32'd0) ? 32'd1 : B;
  assign mag_q   = a_mag / b_safe;
  assign mag_r   = a_mag % b_safe;
  assign squot   = (A[31] ^ B[31]) ? (32'd0 - mag_q) : mag_q;
  assign srem    = A[31] ? (32'd0 - mag_r) : mag_r;

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = 1'b0;
    case (md_op_t'(MDOp))
      MD_MULT:  {res_hi, res_lo} = sprod;
      MD_MULTU: {res_hi, res_lo} = uprod;
      MD_DIV: begin
        res_hi   = srem;
        res_lo   = squot;
        div_zero = (B == 32'd0);
      end
      MD_DIVU: begin
        res_hi   = A % bu_safe;
        res_lo   = A / bu_safe;
        div_zero = (B == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit: computes at the start edge, holds busy
// for a fixed latency, then commits the pending result to HI/LO.
module mult_div_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [31:0] res_hi_reg, res_lo_reg;
  logic        pend_wr_reg;
  logic        busy_reg;
  logic [31:0] hi_reg, lo_reg;

  logic [31:0] res_hi, res_lo;
  logic        div_zero;

  md_compute u_compute (
    .A        (A),
    .B        (B),
    .MDOp     (MDOp),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= 16'd0;
      res_hi_reg  <= 32'd0;
      res_lo_reg  <= 32'd0;
      pend_wr_reg <= 1'b0;
      busy_reg    <= 1'b0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            case (md_op_t'(MDOp))
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                res_hi_reg  <= res_hi;
                res_lo_reg  <= res_lo;
                pend_wr_reg <= !div_zero;
                cnt_reg     <= (md_op_t'(MDOp) == MD_MULT || md_op_t'(MDOp) == MD_MULTU)
                               ? 16'(MULT_CYCLES - 1) : 16'(DIV_CYCLES - 1);
                busy_reg    <= 1'b1;
                state_reg   <= RUN;
              end
              MD_MTHI: hi_reg <= A;
              MD_MTLO: lo_reg <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt_reg == 16'd0) begin
            // Divide-by-zero runs the full latency but leaves HI/LO alone.
            if (pend_wr_reg) begin
              hi_reg <= res_hi_reg;
              lo_reg <= res_lo_reg;
            end
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: table of arithmetic
// vectors plus hand sequences for mthi/divide-by-zero, ignored starts and reset abort.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic [2:0]  MDOp;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .MDOp  (MDOp),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          n;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the start edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp  = op;
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    MDOp  = 3'b000;
    A     = 32'hA5A5_A5A5;
    B     = 32'h5A5A_5A5A;
  endtask

  // Counts busy cycles from the current negedge; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic [31:0] saved_lo;
    vecs[0] = '{3'b001, 32'hFFFF_FFFF, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 5};
    vecs[1] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2] = '{3'b011, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[4] = '{3'b100, 32'd100,       32'd7,        32'd2,         32'd14,        10};
    vecs[5] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[6] = '{3'b011, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};

    rst_n = 1'b0; start = 1'b0; MDOp = 3'b000; A = 32'd0; B = 32'd0;
    @(negedge clk); @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(n), 32'(vecs[i].n));
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      $display("vec %0d op=%0d a=%08h b=%08h busy=%0d hi=%08h lo=%08h",
               i, vecs[i].op, vecs[i].a, vecs[i].b, n, hi, lo);
    end

    // mthi is immediate, then divu by zero keeps HI/LO.
    saved_lo = lo;
    start_op(3'b101, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_lo_kept", lo, saved_lo);
    $display("mthi hi=%08h lo=%08h", hi, lo);
    start_op(3'b100, 32'd9, 32'd0);
    wait_idle(n);
    chk("divz_busy_cycles", 32'(n), 32'd10);
    chk("divz_hi", hi, 32'h1234_5678);
    chk("divz_lo", lo, saved_lo);
    $display("divu 9/0 busy=%0d hi=%08h lo=%08h", n, hi, lo);

    // mtlo during busy is ignored; back-to-back start after busy falls.
    start_op(3'b001, 32'd3, 32'd4);
    MDOp = 3'b110; A = 32'h0000_DEAD; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDOp = 3'b000;
    chk("mtlo_ignored_lo", lo, saved_lo);
    wait_idle(n);
    chk("mult_with_mtlo_busy", 32'(n + 1), 32'd5);
    chk("mult_with_mtlo_lo", lo, 32'd12);
    chk("mult_with_mtlo_hi", hi, 32'd0);
    $display("mult 3*4 with mtlo during busy: busy=%0d hi=%08h lo=%08h", n + 1, hi, lo);
    start_op(3'b010, 32'd2, 32'd3);
    chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("b2b_busy_cycles", 32'(n), 32'd5);
    chk("b2b_lo", lo, 32'd6);
    $display("multu 2*3 back-to-back busy=%0d lo=%08h", n, lo);

    // Reset in busy cycle 3 aborts the divide.
    start_op(3'b100, 32'd100, 32'd7);
    @(negedge clk); @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (busy || hi != 32'd0 || lo != 32'd0) n++;
    end
    chk("abort_no_commit", 32'(n), 32'd0);
    $display("reset abort: busy=%0d hi=%08h lo=%08h", busy, hi, lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
